// File: rtl/light_pkg.sv
// Shared definitions for the light-stick LED drivers: default sizes,
// fade FSM states and the channel slice helper.
package light_pkg;
  localparam int CH_DEF = 3;
  localparam int W_DEF  = 8;

  typedef enum logic {IDLE = 1'b0, FADE = 1'b1} fade_state_e;

  // LSB position of channel c inside a flat CH*W vector
  function automatic int ch_lsb(input int c, input int w);
    return c * w;
  endfunction
endpackage

// File: rtl/rgb_fade_pwm_if.sv
// Command handshake between the pattern player and the LED fade driver.
interface rgb_fade_pwm_if #(
  parameter int CH = light_pkg::CH_DEF,
  parameter int W  = light_pkg::W_DEF
);
  logic            load_valid;
  logic            load_ready;
  logic [CH*W-1:0] load_target;
  logic            load_snap;
  logic [7:0]      load_rate;

  modport master (output load_valid, load_target, load_snap, load_rate,
                  input  load_ready);
  modport slave  (input  load_valid, load_target, load_snap, load_rate,
                  output load_ready);
endinterface

// File: rtl/fade_channel.sv
// One LED channel: working level with +/-1 fade step, frame-latched shadow
// and the PWM compare against the shared period counter.
module fade_channel #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] target,
  input  logic         frame_end,
  input  logic [W-1:0] cnt,
  output logic [W-1:0] level,
  output logic         at_target,
  output logic         pwm
);
  logic [W-1:0] shadow;

  assign at_target = (level == target);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level  <= '0;
      shadow <= '0;
      pwm    <= 1'b0;
    end else begin
      if (load)
        level <= load_val;
      else if (step && !at_target)
        level <= (level < target) ? level + 1'b1 : level - 1'b1;
      // shadow only moves at the period boundary so each period is glitch-free
      if (frame_end)
        shadow <= level;
      pwm <= (cnt < shadow);
    end
  end
endmodule

// File: rtl/rgb_fade_pwm.sv
// Multi-channel LED driver: snap or linear fade to a commanded colour,
// with levels handed to the PWM only on frame boundaries.
module rgb_fade_pwm
  import light_pkg::*;
#(
  parameter int CH       = CH_DEF,
  parameter int W        = W_DEF,
  parameter int STEP_DIV = 1024
) (
  input  logic            clock,
  input  logic            reset_n,
  rgb_fade_pwm_if.slave   bus,
  input  logic            stop,
  output logic            busy,
  output logic [CH*W-1:0] level,
  output logic            frame_tick,
  output logic [CH-1:0]   pwm_out
);
  localparam int           PW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(STEP_DIV - 1);
  localparam logic [W-1:0]  CLAST = ~W'(1);

  fade_state_e     state;
  logic [7:0]      rate, rcnt;
  logic [PW-1:0]   pcnt;
  logic [CH*W-1:0] target;
  logic [W-1:0]    cnt;
  logic [CH-1:0]   at_tgt;
  logic            accept, snap_ld, step, all_at, frame_end;

  assign accept    = bus.load_valid && bus.load_ready;
  assign snap_ld   = accept && bus.load_snap;
  // stop freezes levels even if it lands on a step cycle
  assign step      = (state == FADE) && (pcnt == PLAST) && (rcnt == rate) && !stop;
  assign all_at    = &at_tgt;
  assign frame_end = (cnt == CLAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bus.load_ready <= 1'b1;
      busy           <= 1'b0;
      rate           <= '0;
      target         <= '0;
      pcnt           <= '0;
      rcnt           <= '0;
    end else if (accept) begin
      target <= bus.load_target;
      rate   <= bus.load_rate;
      pcnt   <= '0;
      rcnt   <= '0;
      if (!bus.load_snap) begin
        state          <= FADE;
        bus.load_ready <= 1'b0;
        busy           <= 1'b1;
      end
    end else if (state == FADE) begin
      if (stop || all_at) begin
        state          <= IDLE;
        bus.load_ready <= 1'b1;
        busy           <= 1'b0;
        pcnt           <= '0;
        rcnt           <= '0;
      end else begin
        pcnt <= (pcnt == PLAST) ? '0 : pcnt + 1'b1;
        if (pcnt == PLAST)
          rcnt <= (rcnt == rate) ? '0 : rcnt + 8'd1;
      end
    end
  end

  // shared PWM period counter, 2^W-1 cycles per frame
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= frame_end ? '0 : cnt + 1'b1;
      frame_tick <= frame_end;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    fade_channel #(.W(W)) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (snap_ld),
      .load_val  (bus.load_target[ch_lsb(c, W) +: W]),
      .step      (step),
      .target    (target[ch_lsb(c, W) +: W]),
      .frame_end (frame_end),
      .cnt       (cnt),
      .level     (level[ch_lsb(c, W) +: W]),
      .at_target (at_tgt[c]),
      .pwm       (pwm_out[c])
    );
  end
endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Directed bench for rgb_fade_pwm with CH=3, W=8, STEP_DIV=4.
module tb_rgb_fade_pwm;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stop = 1'b0;
  logic        busy, frame_tick;
  logic [23:0] level;
  logic [2:0]  pwm_out;
  int          checks = 0;
  int          failures = 0;
  int          n;
  int          hi [3];

  rgb_fade_pwm_if #(.CH(3), .W(8)) bus ();

  rgb_fade_pwm #(.CH(3), .W(8), .STEP_DIV(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .stop       (stop),
    .busy       (busy),
    .level      (level),
    .frame_tick (frame_tick),
    .pwm_out    (pwm_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic load(input logic snap, input logic [7:0] rate, input logic [23:0] tgt);
    bus.load_valid  = 1'b1;
    bus.load_snap   = snap;
    bus.load_rate   = rate;
    bus.load_target = tgt;
    cyc(1);
    bus.load_valid  = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int k = 0;
    do begin cyc(1); k++; end while (!frame_tick && k < 300);
    chk(tag, 32'(frame_tick), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 2000) begin cyc(1); k++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    bus.load_valid = 1'b0; bus.load_snap = 1'b0;
    bus.load_rate = '0;    bus.load_target = '0;

    // reset held with random inputs
    repeat (4) begin
      bus.load_valid  = 1'($urandom);
      bus.load_snap   = 1'($urandom);
      bus.load_target = 24'($urandom);
      bus.load_rate   = 8'($urandom);
      stop            = 1'($urandom);
      cyc(1);
    end
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.load_ready), 32'd1);
    chk("rst_tick",  32'(frame_tick), 32'd0);
    chk("rst_pwm",   32'(pwm_out), 32'd0);
    bus.load_valid = 1'b0; bus.load_snap = 1'b0;
    bus.load_target = '0;  bus.load_rate = '0; stop = 1'b0;
    reset_n = 1'b1;
    n = 0;
    do begin cyc(1); n++; end while (!frame_tick && n < 400);
    chk("first_tick", 32'(n), 32'd255);

    // snap to R=255 G=0 B=128
    load(1'b1, 8'd0, {8'd128, 8'd0, 8'd255});
    chk("snap_level", 32'(level), 32'h8000FF);
    chk("snap_busy",  32'(busy), 32'd0);
    chk("snap_ready", 32'(bus.load_ready), 32'd1);
    wait_tick("snap_tick1");
    wait_tick("snap_tick2");
    hi = '{0, 0, 0};
    for (int i = 0; i < 255; i++) begin
      for (int c = 0; c < 3; c++) hi[c] += int'(pwm_out[c]);
      cyc(1);
    end
    chk("pwm_r", 32'(hi[0]), 32'd255);
    chk("pwm_g", 32'(hi[1]), 32'd0);
    chk("pwm_b", 32'(hi[2]), 32'd128);

    // fade R 0->10 at rate 1: one step per 8 cycles
    load(1'b1, 8'd0, 24'd0);
    load(1'b0, 8'd1, 24'd10);
    chk("fade_busy",  32'(busy), 32'd1);
    chk("fade_ready", 32'(bus.load_ready), 32'd0);
    chk("fade_lvl0",  32'(level), 32'd0);
    cyc(7);
    chk("fade_lvl_e7", 32'(level), 32'd0);
    cyc(1);
    chk("fade_lvl_e8", 32'(level), 32'd1);
    bus.load_valid = 1'b1; bus.load_snap = 1'b1; bus.load_target = 24'hFFFFFF;
    cyc(1);
    bus.load_valid = 1'b0;
    chk("fade_ignore_load", 32'(level), 32'd1);
    n = 9;
    while (busy && n < 200) begin cyc(1); n++; end
    chk("fade_busy_fall", 32'(n), 32'd81);
    chk("fade_final",     32'(level), 32'd10);
    chk("fade_ready_up",  32'(bus.load_ready), 32'd1);

    // mixed directions, rate 0: one step per 4 cycles
    load(1'b1, 8'd0, {8'd5, 8'd5, 8'd20});
    load(1'b0, 8'd0, {8'd8, 8'd5, 8'd10});
    cyc(12);
    chk("mix_3steps",  32'(level), 32'h080511);
    cyc(4);
    chk("mix_4steps",  32'(level), 32'h080510);
    cyc(24);
    chk("mix_10steps", 32'(level), 32'h08050A);
    chk("mix_busy10",  32'(busy), 32'd1);
    cyc(1);
    chk("mix_exit",    32'(busy), 32'd0);
    chk("mix_ready",   32'(bus.load_ready), 32'd1);

    // stop at R=4, with a competing load that must be refused
    load(1'b1, 8'd0, 24'd0);
    load(1'b0, 8'd0, 24'd10);
    cyc(16);
    chk("stop_pre", 32'(level), 32'd4);
    stop = 1'b1;
    bus.load_valid = 1'b1; bus.load_snap = 1'b1; bus.load_target = 24'hFFFFFF;
    cyc(1);
    stop = 1'b0; bus.load_valid = 1'b0;
    chk("stop_busy",  32'(busy), 32'd0);
    chk("stop_ready", 32'(bus.load_ready), 32'd1);
    chk("stop_level", 32'(level), 32'd4);
    cyc(8);
    chk("stop_hold",  32'(level), 32'd4);

    // load and stop together in IDLE: load wins
    stop = 1'b1;
    load(1'b0, 8'd0, 24'd6);
    stop = 1'b0;
    chk("loadwins_busy", 32'(busy), 32'd1);
    wait_idle("loadwins_idle");
    chk("loadwins_level", 32'(level), 32'd6);

    // fade to current level: one-cycle busy pulse
    load(1'b0, 8'd0, 24'd6);
    chk("noop_busy",  32'(busy), 32'd1);
    chk("noop_ready", 32'(bus.load_ready), 32'd0);
    cyc(1);
    chk("noop_done",  32'(busy), 32'd0);
    chk("noop_rdy",   32'(bus.load_ready), 32'd1);
    chk("noop_level", 32'(level), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
